// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch controller.
// FSM state encoding used by the top and its helpers.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_st_e;

endpackage

// File: rtl/pc_fetch_ctrl_branch_pend.sv
// Pending-redirect tracker: holds one branch target until
// the PC load that consumes it; the first branch wins.
module fetch_branch_pend
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int Reg_Width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_active,
  input  logic                 i_branch,
  input  logic [Reg_Width-1:0] i_target,
  input  logic                 i_clr,
  output logic                 o_pend,
  output logic [Reg_Width-1:0] o_tgt
);

  logic                 r_pend;
  logic [Reg_Width-1:0] r_tgt;
  logic                 w_set;

  assign w_set  = i_branch & ~r_pend & i_active;
  assign o_pend = r_pend;
  assign o_tgt  = r_tgt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= 1'b0;
      r_tgt  <= '0;
    end else if (w_set) begin
      r_pend <= 1'b1;
      r_tgt  <= i_target;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer driving the PC register
// strobes, with single-delay-slot branch redirects.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int Reg_Width   = 16,
  parameter int Instr_Width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [Reg_Width-1:0]   pc_value,
  output logic                   pc_load,
  output logic                   pc_inc,
  output logic [Reg_Width-1:0]   pc_load_data,
  input  logic                   branch_taken,
  input  logic [Reg_Width-1:0]   branch_target,
  output logic                   mem_req,
  output logic [Reg_Width-1:0]   mem_addr,
  input  logic [Instr_Width-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [Instr_Width-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   dec_ready
);

  fetch_st_e              r_st;
  fetch_st_e              w_nxt;
  logic [Reg_Width-1:0]   r_addr;
  logic [Instr_Width-1:0] r_instr;
  logic                   w_pend;
  logic [Reg_Width-1:0]   w_tgt;

  fetch_branch_pend #(
    .Reg_Width(Reg_Width)
  ) u_pend (
    .clk     (clk),
    .reset   (reset),
    .i_active(r_st != ST_IDLE),
    .i_branch(branch_taken),
    .i_target(branch_target),
    .i_clr   (pc_load),
    .o_pend  (w_pend),
    .o_tgt   (w_tgt)
  );

  assign pc_load_data = w_tgt;
  assign instr_out    = r_instr;

  always_comb begin
    w_nxt       = r_st;
    mem_req     = 1'b0;
    mem_addr    = '0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    instr_valid = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (start) w_nxt = ST_REQ;
      end
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_value;
        w_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        mem_req  = 1'b1;
        mem_addr = r_addr;
        if (mem_ack) begin
          pc_load = w_pend;
          pc_inc  = ~w_pend;
          w_nxt   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        // Increment already happened at ack; only a redirect remains
        if (dec_ready) begin
          pc_load = w_pend;
          w_nxt   = stop ? ST_IDLE : ST_REQ;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st    <= ST_IDLE;
      r_addr  <= '0;
      r_instr <= '0;
    end else begin
      r_st <= w_nxt;
      if (r_st == ST_REQ) r_addr <= pc_value;
      if (r_st == ST_WAIT && mem_ack) r_instr <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized
// traffic against a fetch-transaction reference model.
module tb_pc_fetch_ctrl;

  localparam int RW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          branch_taken = 1'b0;
  logic [RW-1:0] branch_target = '0;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          dec_ready = 1'b0;
  logic [RW-1:0] pc_value;
  logic          pc_load, pc_inc, mem_req, instr_valid;
  logic [RW-1:0] pc_load_data, mem_addr;
  logic [IW-1:0] instr_out;

  int n_vec = 0;
  int n_err = 0;

  // Environment: the PC register this block controls
  logic [RW-1:0] pc_reg = 16'h0010;
  assign pc_value = pc_reg;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.Reg_Width(RW), .Instr_Width(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .pc_value     (pc_value),
    .pc_load      (pc_load),
    .pc_inc       (pc_inc),
    .pc_load_data (pc_load_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .dec_ready    (dec_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a fetch is outstanding (first cycle latches the PC),
  // or a word is held for decode, or neither (idle).
  bit            m_fetch, m_first, m_have, m_pend;
  logic [RW-1:0] m_addr, m_tgt;
  logic [IW-1:0] m_word;
  bit            n_fetch, n_first, n_have, n_pend;
  logic [RW-1:0] n_addr, n_tgt;
  logic [IW-1:0] n_word;
  bit            s_ld, s_inc;
  logic [RW-1:0] s_data;

  initial begin
    m_fetch = 0; m_first = 0; m_have = 0; m_pend = 0;
    m_addr = '0; m_tgt = '0; m_word = '0;
    n_fetch = 0; n_first = 0; n_have = 0; n_pend = 0;
    n_addr = '0; n_tgt = '0; n_word = '0;
    s_ld = 0; s_inc = 0; s_data = '0;
  end

  always @(negedge clk) begin : compare
    bit e_ld, e_inc;
    s_ld = 0;
    s_inc = 0;
    if (!reset) begin
      m_fetch = 0; m_first = 0; m_have = 0; m_pend = 0;
      m_addr = '0; m_tgt = '0; m_word = '0;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_pc_load", pc_load, 0);
      chk("rst_pc_inc", pc_inc, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr_out, 0);
      chk("rst_ld_data", pc_load_data, 0);
    end else begin
      e_ld = 0;
      e_inc = 0;
      if (m_fetch && !m_first && mem_ack) begin
        if (m_pend) e_ld = 1;
        else e_inc = 1;
      end
      if (m_have && dec_ready && m_pend) e_ld = 1;
      chk("m_mem_req", mem_req, m_fetch);
      if (m_fetch)
        chk("m_mem_addr", mem_addr, m_first ? pc_value : m_addr);
      chk("m_pc_load", pc_load, e_ld);
      chk("m_pc_inc", pc_inc, e_inc);
      chk("m_ld_data", pc_load_data, m_tgt);
      chk("m_valid", instr_valid, m_have);
      chk("m_instr", instr_out, m_word);
      s_ld = pc_load;
      s_inc = pc_inc;
      s_data = pc_load_data;
      n_pend = m_pend;
      n_tgt = m_tgt;
      if (e_ld) n_pend = 0;
      if (branch_taken && !m_pend && (m_fetch || m_have)) begin
        n_pend = 1;
        n_tgt = branch_target;
      end
    end
    n_fetch = m_fetch; n_first = m_first; n_have = m_have;
    n_addr = m_addr; n_word = m_word;
    if (!reset) begin
      n_pend = 0;
      n_tgt = '0;
    end else if (!m_fetch && !m_have) begin
      if (start) begin n_fetch = 1; n_first = 1; end
    end else if (m_fetch && m_first) begin
      n_addr = pc_value;
      n_first = 0;
    end else if (m_fetch && mem_ack) begin
      n_fetch = 0;
      n_have = 1;
      n_word = mem_rdata;
    end else if (m_have && dec_ready) begin
      n_have = 0;
      if (!stop) begin n_fetch = 1; n_first = 1; end
    end
  end

  always @(posedge clk) begin
    m_fetch = n_fetch; m_first = n_first; m_have = n_have;
    m_pend = n_pend; m_addr = n_addr; m_tgt = n_tgt;
    m_word = n_word;
    if (s_ld) pc_reg <= s_data;
    else if (s_inc) pc_reg <= pc_reg + 1'b1;
    s_ld = 0;
    s_inc = 0;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_req", mem_req, 0);
    chk("idle_valid", instr_valid, 0);
    chk("idle_inc", pc_inc, 0);
    // Basic fetch from 0x0010
    tick(); start = 1;
    tick(); start = 0; dec_ready = 1;
    @(negedge clk);
    chk("t2_req", mem_req, 1);
    chk("t2_addr", mem_addr, 16'h0010);
    tick(); mem_ack = 1; mem_rdata = 16'hABCD;
    @(negedge clk);
    chk("t2_inc", pc_inc, 1);
    chk("t2_noload", pc_load, 0);
    tick(); mem_ack = 0;
    @(negedge clk);
    chk("t2_valid", instr_valid, 1);
    chk("t2_instr", instr_out, 16'hABCD);
    tick();
    @(negedge clk);
    chk("t2_loop_req", mem_req, 1);
    chk("t2_next_addr", mem_addr, 16'h0011);
    // Slow memory: ack on the fourth wait cycle
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("t3_req_held", mem_req, 1);
      chk("t3_addr_stable", mem_addr, 16'h0011);
      chk("t3_no_inc", pc_inc, 0);
    end
    tick(); mem_ack = 1; mem_rdata = 16'h1234;
    @(negedge clk);
    chk("t3_inc", pc_inc, 1);
    tick(); mem_ack = 0;
    @(negedge clk);
    chk("t3_instr", instr_out, 16'h1234);
    tick();
    @(negedge clk);
    chk("t3_next_addr", mem_addr, 16'h0012);
    // Branch during WAIT
    tick(); branch_taken = 1; branch_target = 16'h0200;
    tick(); branch_taken = 0; mem_ack = 1; mem_rdata = 16'h2222;
    @(negedge clk);
    chk("t4_load", pc_load, 1);
    chk("t4_ld_data", pc_load_data, 16'h0200);
    chk("t4_no_inc", pc_inc, 0);
    tick(); mem_ack = 0;
    @(negedge clk);
    chk("t4_slot_instr", instr_out, 16'h2222);
    tick();
    @(negedge clk);
    chk("t4_redirect", mem_addr, 16'h0200);
    // Branch during a stalled HOLD; second branch ignored
    tick(); mem_ack = 1; mem_rdata = 16'h5555;
    tick(); mem_ack = 0; dec_ready = 0;
    branch_taken = 1; branch_target = 16'h0300;
    tick(); branch_target = 16'h0400;
    @(negedge clk);
    chk("t5_stable", instr_out, 16'h5555);
    chk("t5_stall_noload", pc_load, 0);
    tick(); branch_taken = 0; dec_ready = 1;
    @(negedge clk);
    chk("t5_load", pc_load, 1);
    chk("t5_ld_data", pc_load_data, 16'h0300);
    tick();
    @(negedge clk);
    chk("t5_redirect", mem_addr, 16'h0300);
    // Stop at HOLD exit
    tick(); mem_ack = 1; mem_rdata = 16'h6666;
    tick(); mem_ack = 0; stop = 1;
    @(negedge clk);
    chk("t6_valid", instr_valid, 1);
    repeat (3) begin
      tick(); stop = 0;
      @(negedge clk);
      chk("t6_idle_req", mem_req, 0);
    end
    // Reset in the middle of a fetch
    tick(); start = 1;
    tick(); start = 0;
    tick();
    reset = 0;
    #1;
    chk("t1_async_req", mem_req, 0);
    chk("t1_async_valid", instr_valid, 0);
    tick(); reset = 1; mem_ack = 1;
    @(negedge clk);
    chk("t1_late_ack_inc", pc_inc, 0);
    chk("t1_late_ack_req", mem_req, 0);
    tick(); mem_ack = 0;
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      mem_ack = mem_req && ($urandom % 3 == 0);
      reset = ($urandom % 300) != 0;
      start = ($urandom % 6) == 0;
      stop = ($urandom % 5) == 0;
      branch_taken = ($urandom % 6) == 0;
      branch_target = RW'($urandom);
      dec_ready = ($urandom % 3) != 0;
      mem_rdata = IW'($urandom);
    end
    tick();
    reset = 1; start = 0; mem_ack = 0; branch_taken = 0;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
